// File: rtl/serial_paralelo_pkg.sv
// Shared constants and state encoding for the serial-to-parallel receiver.
package serial_paralelo_pkg;
   localparam logic [7:0] COM        = 8'hBC;
   localparam int         SYNC_COUNT = 4;
   localparam int         LOS_COUNT  = 4;

   typedef enum logic [1:0] {SEARCH, COUNT, ACTIVE} state_t;
endpackage

// File: rtl/sp_shift_reg.sv
// 8-bit MSB-first input shift register; next_sr is the window including the bit sampled this edge.
module sp_shift_reg (
   input  logic       clk_32f,
   input  logic       reset_L,
   input  logic       data_in,
   output logic [7:0] next_sr
);
   logic [7:0] sr;

   assign next_sr = {sr[6:0], data_in};

   always_ff @(posedge clk_32f or negedge reset_L) begin
      if (!reset_L) sr <= 8'h00;
      else          sr <= next_sr;
   end
endmodule

// File: rtl/serial_paralelo.sv
// Serial-to-parallel receiver: aligns on COM bytes, then emits data bytes at each byte boundary.
// Optional loss-of-sync detection on runs of 8'h00 is built when SERIAL_PARALELO_LOS_EN is defined.
module serial_paralelo
   import serial_paralelo_pkg::*;
(
   input  logic       clk_32f,
   input  logic       reset_L,
   input  logic       data_in,
   output logic [7:0] data_out,
   output logic       valid_out,
   output logic       active
);
   state_t     state;
   logic [7:0] next_sr;
   logic [2:0] bit_cnt;
   logic [2:0] bc_cnt;
   logic       boundary;
`ifdef SERIAL_PARALELO_LOS_EN
   logic [2:0] los_cnt;
`endif

   sp_shift_reg u_sr (
      .clk_32f (clk_32f),
      .reset_L (reset_L),
      .data_in (data_in),
      .next_sr (next_sr)
   );

   assign boundary = (bit_cnt == 3'd7);

   always_ff @(posedge clk_32f or negedge reset_L) begin
      if (!reset_L) begin
         state     <= SEARCH;
         bit_cnt   <= 3'd0;
         bc_cnt    <= 3'd0;
         data_out  <= 8'h00;
         valid_out <= 1'b0;
         active    <= 1'b0;
`ifdef SERIAL_PARALELO_LOS_EN
         los_cnt   <= 3'd0;
`endif
      end else begin
         case (state)
            SEARCH: begin
               data_out  <= 8'h00;
               valid_out <= 1'b0;
               active    <= 1'b0;
               if (next_sr == COM) begin
                  state   <= COUNT;
                  bc_cnt  <= 3'd1;
                  bit_cnt <= 3'd0;
               end
            end
            COUNT: begin
               bit_cnt <= bit_cnt + 3'd1;
               if (boundary) begin
                  if (next_sr == COM) begin
                     bc_cnt <= bc_cnt + 3'd1;
                     if (bc_cnt + 3'd1 == 3'(SYNC_COUNT)) begin
                        state  <= ACTIVE;
                        active <= 1'b1;
                     end
                  end else begin
                     // Misaligned byte: drop back without re-searching this window.
                     state   <= SEARCH;
                     bc_cnt  <= 3'd0;
                     bit_cnt <= 3'd0;
                  end
               end
            end
            ACTIVE: begin
               bit_cnt <= bit_cnt + 3'd1;
               if (boundary) begin
`ifdef SERIAL_PARALELO_LOS_EN
                  if (next_sr == 8'h00) begin
                     if (los_cnt + 3'd1 == 3'(LOS_COUNT)) begin
                        state     <= SEARCH;
                        active    <= 1'b0;
                        valid_out <= 1'b0;
                        data_out  <= 8'h00;
                        los_cnt   <= 3'd0;
                        bc_cnt    <= 3'd0;
                        bit_cnt   <= 3'd0;
                     end else begin
                        los_cnt   <= los_cnt + 3'd1;
                        data_out  <= next_sr;
                        valid_out <= 1'b1;
                     end
                  end else begin
                     los_cnt <= 3'd0;
                     if (next_sr != COM) begin
                        data_out  <= next_sr;
                        valid_out <= 1'b1;
                     end else begin
                        valid_out <= 1'b0;
                     end
                  end
`else
                  if (next_sr != COM) begin
                     data_out  <= next_sr;
                     valid_out <= 1'b1;
                  end else begin
                     valid_out <= 1'b0;
                  end
`endif
               end
            end
            default: state <= SEARCH;
         endcase
      end
   end
endmodule

// File: tb/tb_serial_paralelo.sv
// Scoreboard bench for serial_paralelo: stimulus queues per-edge expectations, a monitor pops and compares.
module tb_serial_paralelo;
   typedef struct packed {
      logic       act;
      logic       vld;
      logic [7:0] dat;
   } exp_t;

   logic       clk_32f = 1'b0;
   logic       reset_L = 1'b0;
   logic       data_in = 1'b0;
   logic [7:0] data_out;
   logic       valid_out;
   logic       active;

   exp_t exp_q[$];
   exp_t cur;
   int   n_chk  = 0;
   int   n_fail = 0;

   localparam logic [7:0] COM = 8'hBC;

   serial_paralelo dut (
      .clk_32f   (clk_32f),
      .reset_L   (reset_L),
      .data_in   (data_in),
      .data_out  (data_out),
      .valid_out (valid_out),
      .active    (active)
   );

   always #5 clk_32f = ~clk_32f;

   // Monitor: one expectation per sampled bit, compared just after the edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk_32f);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_chk++;
            if (active !== e.act || valid_out !== e.vld || data_out !== e.dat) begin
               n_fail++;
               $display("FAIL out_chk t=%0t: act/vld/data got %b/%b/%h expected %b/%b/%h",
                        $time, active, valid_out, data_out, e.act, e.vld, e.dat);
            end
         end
      end
   end

   task automatic send_bit(input logic b, input exp_t e);
      @(negedge clk_32f);
      data_in = b;
      @(posedge clk_32f);
      exp_q.push_back(e);
   endtask

   // Outputs hold the previous value for bits 7..1, take the new value on the 8th bit.
   task automatic send_byte(input logic [7:0] b, input logic a, input logic v, input logic [7:0] d);
      exp_t nxt;
      nxt = '{act: a, vld: v, dat: d};
      for (int i = 7; i >= 0; i--)
         send_bit(b[i], (i == 0) ? nxt : cur);
      cur = nxt;
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk_32f);
      reset_L = 1'b0;
      #1;
      n_chk++;
      if (active !== 1'b0 || valid_out !== 1'b0 || data_out !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_%s: act/vld/data got %b/%b/%h expected 0/0/00",
                  tag, active, valid_out, data_out);
      end
      @(negedge clk_32f);
      reset_L = 1'b1;
      cur = '0;
   endtask

   initial begin
      cur = '0;
      // Reset state and 4 aligned COMs, then data/COM/data in ACTIVE.
      do_reset("init");
      send_byte(COM, 1'b0, 1'b0, 8'h00);
      send_byte(COM, 1'b0, 1'b0, 8'h00);
      send_byte(COM, 1'b0, 1'b0, 8'h00);
      send_byte(COM, 1'b1, 1'b0, 8'h00);
      send_byte(8'hAA, 1'b1, 1'b1, 8'hAA);
      send_byte(COM,   1'b1, 1'b0, 8'hAA);
      send_byte(8'h88, 1'b1, 1'b1, 8'h88);

      // Reset mid-byte in ACTIVE; partial bits are discarded.
      send_bit(1'b1, cur);
      send_bit(1'b0, cur);
      send_bit(1'b1, cur);
      do_reset("mid");
      send_byte(COM, 1'b0, 1'b0, 8'h00);
      send_byte(COM, 1'b0, 1'b0, 8'h00);
      send_byte(COM, 1'b0, 1'b0, 8'h00);
      send_byte(COM, 1'b1, 1'b0, 8'h00);
      send_byte(8'h5A, 1'b1, 1'b1, 8'h5A);

      // Three-bit offset before alignment.
      do_reset("offs");
      send_bit(1'b1, cur);
      send_bit(1'b0, cur);
      send_bit(1'b1, cur);
      send_byte(COM, 1'b0, 1'b0, 8'h00);
      send_byte(COM, 1'b0, 1'b0, 8'h00);
      send_byte(COM, 1'b0, 1'b0, 8'h00);
      send_byte(COM, 1'b1, 1'b0, 8'h00);
      send_byte(8'hFF, 1'b1, 1'b1, 8'hFF);
      send_byte(8'hEE, 1'b1, 1'b1, 8'hEE);

      // Broken COM run: back to SEARCH, needs 4 fresh COMs.
      do_reset("brk");
      send_byte(COM,   1'b0, 1'b0, 8'h00);
      send_byte(COM,   1'b0, 1'b0, 8'h00);
      send_byte(8'h12, 1'b0, 1'b0, 8'h00);
      send_byte(COM,   1'b0, 1'b0, 8'h00);
      send_byte(COM,   1'b0, 1'b0, 8'h00);
      send_byte(COM,   1'b0, 1'b0, 8'h00);
      send_byte(COM,   1'b1, 1'b0, 8'h00);
      send_byte(8'h34, 1'b1, 1'b1, 8'h34);

      // Run of zero bytes in ACTIVE.
      send_byte(8'h00, 1'b1, 1'b1, 8'h00);
      send_byte(8'h00, 1'b1, 1'b1, 8'h00);
      send_byte(8'h00, 1'b1, 1'b1, 8'h00);
`ifdef SERIAL_PARALELO_LOS_EN
      send_byte(8'h00, 1'b0, 1'b0, 8'h00);
      send_byte(8'h77, 1'b0, 1'b0, 8'h00);
`else
      send_byte(8'h00, 1'b1, 1'b1, 8'h00);
      send_byte(8'h77, 1'b1, 1'b1, 8'h77);
`endif

      repeat (3) @(posedge clk_32f);
      #2;
      n_chk++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: queue left %0d expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
